// File: rtl/wb_regfile_pkg.sv
// Shared constants for the write-back / register-file slice of the CPU pipeline.
// Default widths and the hardwired-zero register index.
package wb_regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 32;

    localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_mux.sv
// Write-back value select: load data from memory or the ALU result.
// Pure combinational 2:1 mux, no latency.
module wb_regfile_mux #(
    parameter int DATA_W = 32
) (
    input  logic              i_sel_mem,
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_data,
    output logic [DATA_W-1:0] o_wb_data
);

    assign o_wb_data = i_sel_mem ? i_mem_data : i_alu_data;

endmodule : wb_regfile_mux

// File: rtl/wb_regfile.sv
// MEM/WB consumer: selects the write-back value, commits it to the architectural
// register file, serves two ID read ports with same-cycle bypass, counts retired writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite_wb,
    input  logic              MemtoReg_wb,
    input  logic [DATA_W-1:0] mem_read_data_wb,
    input  logic [DATA_W-1:0] alu_result_wb,
    input  logic [ADDR_W-1:0] write_reg_wb,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int NUM_RD   = 2;

    logic [DATA_W-1:0]        r_regs [NUM_REGS];
    logic [CNT_W-1:0]         r_retired_cnt;
    logic [DATA_W-1:0]        w_wb_data;
    logic                     w_commit;
    logic [NUM_RD*ADDR_W-1:0] w_rd_addr;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;

    wb_regfile_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .i_sel_mem  (MemtoReg_wb),
        .i_mem_data (mem_read_data_wb),
        .i_alu_data (alu_result_wb),
        .o_wb_data  (w_wb_data)
    );

    // Writes aimed at the zero register are dropped entirely, including from the count.
    assign w_commit = RegWrite_wb && (write_reg_wb != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[write_reg_wb] <= w_wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_retired_cnt <= '0;
        end else if (w_commit) begin
            r_retired_cnt <= r_retired_cnt + CNT_W'(1);
        end
    end

    assign w_rd_addr = {rt_addr, rs_addr};

    // Bypass gives write-before-read: ID sees the value WB commits this same cycle.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd_port
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = w_rd_addr[gi*ADDR_W +: ADDR_W];
            assign w_rd_data[gi*DATA_W +: DATA_W] =
                (w_addr == ADDR_W'(REG_ZERO))              ? '0        :
                (RegWrite_wb && (write_reg_wb == w_addr)) ? w_wb_data :
                                                            r_regs[w_addr];
        end
    endgenerate

    assign rs_data     = w_rd_data[0 +: DATA_W];
    assign rt_data     = w_rd_data[DATA_W +: DATA_W];
    assign wb_data     = w_wb_data;
    assign retired_cnt = r_retired_cnt;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset corner case,
// then randomized traffic checked against an array-based reference model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_wb;
    logic        MemtoReg_wb;
    logic [31:0] mem_read_data_wb;
    logic [31:0] alu_result_wb;
    logic [4:0]  write_reg_wb;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [31:0] retired_cnt;

    int errors = 0;
    int checks = 0;

    wb_regfile dut (
        .clk              (clk),
        .reset            (reset),
        .RegWrite_wb      (RegWrite_wb),
        .MemtoReg_wb      (MemtoReg_wb),
        .mem_read_data_wb (mem_read_data_wb),
        .alu_result_wb    (alu_result_wb),
        .write_reg_wb     (write_reg_wb),
        .rs_addr          (rs_addr),
        .rt_addr          (rt_addr),
        .rs_data          (rs_data),
        .rt_data          (rt_data),
        .wb_data          (wb_data),
        .retired_cnt      (retired_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          we;
        bit          m2r;
        logic [31:0] mem;
        logic [31:0] alu;
        logic [4:0]  wr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [31:0] e_wb;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[9];

    logic [31:0] m_regs [32];
    logic [31:0] m_img  [32];
    int unsigned m_cnt;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic drive(input bit we, input bit m2r, input logic [31:0] mem,
                         input logic [31:0] alu, input logic [4:0] wr,
                         input logic [4:0] rs, input logic [4:0] rt);
        RegWrite_wb      = we;
        MemtoReg_wb      = m2r;
        mem_read_data_wb = mem;
        alu_result_wb    = alu;
        write_reg_wb     = wr;
        rs_addr          = rs;
        rt_addr          = rt;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1, 0, 32'h0,        32'hDEADBEEF, 5, 5, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1};
        vecs[1] = '{0, 0, 32'h0,        32'h0,        5, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        1};
        vecs[2] = '{1, 1, 32'h12345678, 32'hFFFFFFFF, 7, 7, 5, 32'h12345678, 32'hDEADBEEF, 32'h12345678, 2};
        vecs[3] = '{0, 1, 32'h0,        32'hFFFFFFFF, 7, 7, 0, 32'h12345678, 32'h0,        32'h0,        2};
        vecs[4] = '{1, 0, 32'h0,        32'hA5A5A5A5, 0, 0, 0, 32'h0,        32'h0,        32'hA5A5A5A5, 2};
        vecs[5] = '{1, 0, 32'h0,        32'h11,       9, 9, 9, 32'h11,       32'h11,       32'h11,       3};
        vecs[6] = '{0, 0, 32'h0,        32'h55,       9, 9, 9, 32'h11,       32'h11,       32'h55,       3};
        vecs[7] = '{1, 0, 32'h0,        32'h55,       9, 9, 9, 32'h55,       32'h55,       32'h55,       4};
        vecs[8] = '{0, 0, 32'h0,        32'h0,        9, 9, 7, 32'h55,       32'h12345678, 32'h0,        4};

        // Reset state
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #2;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            chk($sformatf("reset_rs[%0d]", a), rs_data, 32'h0);
            chk($sformatf("reset_rt[%0d]", 31 - a), rt_data, 32'h0);
        end
        chk("reset_cnt", retired_cnt, 32'h0);
        @(posedge clk); #1;

        // Directed vectors
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].we, vecs[v].m2r, vecs[v].mem, vecs[v].alu,
                  vecs[v].wr, vecs[v].rs, vecs[v].rt);
            #2;
            chk($sformatf("vec%0d_wb", v), wb_data, vecs[v].e_wb);
            chk($sformatf("vec%0d_rs", v), rs_data, vecs[v].e_rs);
            chk($sformatf("vec%0d_rt", v), rt_data, vecs[v].e_rt);
            @(posedge clk); #1;
            chk($sformatf("vec%0d_cnt", v), retired_cnt, vecs[v].e_cnt);
            $display("vec %0d: we=%0d wr=%0d rs=%h rt=%h wb=%h cnt=%0d",
                     v, vecs[v].we, vecs[v].wr, rs_data, rt_data, wb_data, retired_cnt);
        end

        // Reset coincident with a pending write to reg3
        drive(1, 0, 0, 32'hCAFE, 3, 3, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 3, 3, 0);
        #1;
        chk("rst6_cafe", rs_data, 32'hCAFE);
        chk("rst6_cnt_pre", retired_cnt, 32'd5);
        drive(1, 0, 0, 32'hBEEF, 3, 3, 3);
        #5 reset = 1'b0;
        #1;
        chk("rst6_cnt_async", retired_cnt, 32'h0);
        @(posedge clk); #1;
        RegWrite_wb = 1'b0;
        reset = 1'b1;
        #2;
        chk("rst6_reg3", rs_data, 32'h0);
        chk("rst6_cnt", retired_cnt, 32'h0);
        @(posedge clk); #1;
        chk("rst6_reg3_later", rt_data, 32'h0);
        chk("rst6_cnt_later", retired_cnt, 32'h0);
        $display("reset-mid-write: reg3=%h cnt=%0d", rt_data, retired_cnt);

        // Randomized traffic against a write-before-read array model
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = 0;
        for (int n = 0; n < 400; n++) begin
            bit          we;
            bit          m2r;
            logic [31:0] mem;
            logic [31:0] alu;
            logic [31:0] val;
            logic [4:0]  wr;
            logic [4:0]  rs;
            logic [4:0]  rt;
            we  = ($urandom_range(0, 3) != 0);
            m2r = $urandom_range(0, 1) == 1;
            mem = $urandom;
            alu = $urandom;
            wr  = 5'($urandom_range(0, 9));
            rs  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 9));
            rt  = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            val = m2r ? mem : alu;
            drive(we, m2r, mem, alu, wr, rs, rt);
            for (int i = 0; i < 32; i++) m_img[i] = m_regs[i];
            if (we && wr != 0) m_img[wr] = val;
            #2;
            chk($sformatf("rnd%0d_wb", n), wb_data, val);
            chk($sformatf("rnd%0d_rs", n), rs_data, m_img[rs]);
            chk($sformatf("rnd%0d_rt", n), rt_data, m_img[rt]);
            @(posedge clk); #1;
            for (int i = 0; i < 32; i++) m_regs[i] = m_img[i];
            if (we && wr != 0) m_cnt++;
            chk($sformatf("rnd%0d_cnt", n), retired_cnt, m_cnt);
            $display("rnd %0d: we=%0d m2r=%0d wr=%0d rs=%0d rt=%0d wb=%h cnt=%0d",
                     n, we, m2r, wr, rs, rt, val, m_cnt);
        end

        // Full array sweep after random traffic
        RegWrite_wb = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            #1;
            chk($sformatf("final_reg%0d", a), rs_data, m_regs[a]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_wb_regfile
